mmu_xlate: RTL and testbench
============================

Name: mmu_xlate

Overview:
- Address-translation stage directly downstream of the TLB array block; consumes its per-entry lookup vector (one instance for fetch, one for data).
- Accepts a virtual address with access type and returns physical address, MAT and exception code.
- Translation modes: direct (CRMD.DA), direct-mapped windows DMW0/DMW1, or page-table lookup against the TLB entries.
- Two-stage pipeline with valid/ready handshakes on both sides.

Parameters:
ENTRY_NUM, 16, number of TLB entries in the lookup vector (power of 2)
IDX_WID, 4, log2(ENTRY_NUM)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
flush  in  1  kill all in-flight requests
req_valid  in  1  request present
req_ready  out  1  request accepted when valid & ready
req_vaddr  in  32  virtual address
req_type  in  2  0=fetch, 1=load, 2=store (3 treated as load)
cur_plv  in  2  CRMD.PLV
cur_asid  in  10  ASID.ASID
crmd_da  in  1  direct-address mode
crmd_datm  in  2  MAT used in direct mode
dmw0  in  32  DMW0 CSR: [0]=PLV0 en, [3]=PLV3 en, [5:4]=MAT, [27:25]=PSEG, [31:29]=VSEG
dmw1  in  32  DMW1 CSR, same layout
lookup  in  ENTRY_NUM x tlb_entry_t  entry vector from the TLB block (e, g, vppn[18:0], ps[5:0], asid[9:0], phy[2]{ppn[19:0], plv[1:0], mat[1:0], d, v})
rsp_valid  out  1  result present
rsp_ready  in  1  consumer accepts result
rsp_paddr  out  32  physical address
rsp_mat  out  2  memory access type
rsp_exc  out  1  translation exception
rsp_ecode  out  6  exception code, 0 when rsp_exc=0
rsp_vaddr  out  32  echoed vaddr (BADV source)

Behaviour:
- Reset: S1/S2 valid=0; rsp_valid=0; rsp_paddr, rsp_mat, rsp_exc, rsp_ecode, rsp_vaddr = 0.
- Stage S1, accept cycle: req_ready = ~S1.v | S2 advancing. S2 advancing = ~S2.v | rsp_ready.
- On accept, S1 registers vaddr, type, cur_plv and mode decision, evaluated in the accept cycle with priority DA > DMW0 > DMW1 > TLB.
- DMWn hit condition: vaddr[31:29]==VSEG and the enable bit for cur_plv is set (plv0 -> bit0, plv3 -> bit3; plv1/2 never hit).
- TLB match, per entry i: e & (g | asid==cur_asid) & vppn compare.
  - ps==12: full 19-bit vppn compare, odd bit = vaddr[12].
  - ps==21: vppn[18:9] compare, odd bit = vaddr[21].
  - Other ps values never match.
  - Lowest matching index wins.
- S1 registers hit flag, odd bit, ps and the selected phy half plus its plv. It is a snapshot: TLB writes in later cycles do not affect in-flight requests. A TLB write in the accept cycle is not yet visible (old entry used).
- S1 -> S2 transfer whenever S2 advancing. S2 holds all rsp_* stable while rsp_valid & ~rsp_ready.
- S2 result, mode DA: paddr = vaddr, mat = crmd_datm, no exception.
- S2 result, mode DMW: paddr = {PSEG, vaddr[28:0]}, mat = DMW.MAT, no exception.
- S2 result, mode TLB:
  - PA: ps==12 -> {ppn, vaddr[11:0]}; ps==21 -> {ppn[19:9], vaddr[20:0]}.
  - mat = phy.mat.
  - Exception priority:
    - no hit -> 0x3F (TLBR)
    - v==0 -> 0x03 PIF / 0x01 PIL / 0x02 PIS by type
    - cur_plv > phy.plv -> 0x07 (PPI)
    - store & d==0 -> 0x04 (PME)
    - else none.
  - On exception, paddr and mat are still driven as computed (0 paddr on TLBR).
- Throughput and latency: one request per cycle when rsp_ready held high. Latency accept -> rsp_valid = 2 cycles.
- flush: S1.v and S2.v cleared next edge. A request offered in the same cycle as flush is not accepted (req_ready=0 while flush=1). rsp_valid falls the cycle after flush.
- Reset asserted mid-operation: all valids clear immediately (async). No response is produced for in-flight requests.

Test Plan:
- crmd_da=1, datm=1, vaddr=0x1C00_0000 load -> 2 cycles later rsp_paddr=0x1C00_0000, mat=1, exc=0.
- da=0, dmw0=0x8000_0011 (vseg=4, pseg=0, mat=1, plv0 en), plv=0, vaddr=0x9000_1234 -> paddr=0x1000_1234, mat=1. Same with plv=3 -> falls to TLB; no match -> ecode 0x3F.
- Entry 5: e=1, g=0, asid=7, vppn=0x00010, ps=12, phy[1]{ppn=0xABCDE, v=1, d=0, plv=3, mat=1}; store to vaddr=0x0002_1008 with asid=7, plv=3 -> paddr=0xABCD_E008, exc=1, ecode=0x04. Same as load -> exc=0.
- Same entry with asid=8 -> ecode 0x3F. Set g=1 -> hit. Set phy[1].v=0 with type fetch -> ecode 0x03. Set phy[1].plv=0, cur_plv=3 -> ecode 0x07.
- Back-to-back 4 requests, rsp_ready low for 3 cycles after the first response -> rsp outputs stable; req_ready=0 once both stages full; all 4 responses delivered in order, none lost or duplicated.
- flush while both stages valid, with a new req_valid -> next cycle rsp_valid=0; flushed requests never appear; the following accepted request returns after 2 cycles.

Source files
------------

// File: rtl/mmu_xlate_if.sv
// Request/response handshake bundle for the mmu_xlate translation stage.
interface mmu_xlate_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_vaddr;
    logic [1:0]  req_type;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_paddr;
    logic [1:0]  rsp_mat;
    logic        rsp_exc;
    logic [5:0]  rsp_ecode;
    logic [31:0] rsp_vaddr;

    // Requester / response consumer side
    modport master (
        output req_valid, req_vaddr, req_type, rsp_ready,
        input  req_ready, rsp_valid, rsp_paddr, rsp_mat, rsp_exc, rsp_ecode, rsp_vaddr
    );

    // Translation stage side
    modport slave (
        input  req_valid, req_vaddr, req_type, rsp_ready,
        output req_ready, rsp_valid, rsp_paddr, rsp_mat, rsp_exc, rsp_ecode, rsp_vaddr
    );
endinterface

// File: rtl/mmu_xlate.sv
// Two-stage virtual-to-physical address translation: direct mode, DMW windows
// or TLB page lookup. S1 snapshots the mode decision and the matching TLB half,
// S2 forms paddr/MAT/exception and holds them under back-pressure.
module mmu_xlate #(
    parameter int unsigned ENTRY_NUM = 16,
    parameter int unsigned IDX_WID   = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    flush,
    input  logic [1:0]              cur_plv,
    input  logic [9:0]              cur_asid,
    input  logic                    crmd_da,
    input  logic [1:0]              crmd_datm,
    input  logic [31:0]             dmw0,
    input  logic [31:0]             dmw1,
    input  logic [ENTRY_NUM*89-1:0] lookup,
    mmu_xlate_if.slave              bus
);

    typedef struct packed {
        logic [19:0] ppn;
        logic [1:0]  plv;
        logic [1:0]  mat;
        logic        d;
        logic        v;
    } tlb_phy_t;

    // Flat lookup layout per entry, MSB first: e, g, vppn, ps, asid, phy[1], phy[0]
    typedef struct packed {
        logic          e;
        logic          g;
        logic [18:0]   vppn;
        logic [5:0]    ps;
        logic [9:0]    asid;
        tlb_phy_t [1:0] phy;
    } tlb_entry_t;

    localparam int unsigned ENTRY_W = $bits(tlb_entry_t);

    typedef enum logic [1:0] {MODE_DA, MODE_DMW, MODE_TLB} mode_e;

    tlb_entry_t ents [ENTRY_NUM];
    logic [ENTRY_NUM-1:0] match;
    logic                 tlb_hit;
    logic [IDX_WID-1:0]   hit_idx;
    tlb_entry_t           sel;
    logic                 odd;
    tlb_phy_t             phy_sel;

    logic        dmw0_hit, dmw1_hit;
    logic        dmw_unused;
    mode_e       mode_d;
    logic [2:0]  seg_d;
    logic [1:0]  dmat_d;

    logic        s1_free, s2_adv, req_fire;

    logic        s1_v_q;
    logic [31:0] s1_vaddr_q;
    logic [1:0]  s1_type_q;
    logic [1:0]  s1_plv_q;
    mode_e       s1_mode_q;
    logic [2:0]  s1_seg_q;
    logic [1:0]  s1_dmat_q;
    logic        s1_hit_q;
    logic        s1_ps21_q;
    tlb_phy_t    s1_phy_q;

    logic        s2_v_q;
    logic [31:0] s2_paddr_q, s2_paddr_d;
    logic [1:0]  s2_mat_q, s2_mat_d;
    logic        s2_exc_q, s2_exc_d;
    logic [5:0]  s2_ecode_q, s2_ecode_d;
    logic [31:0] s2_vaddr_q;

    assign dmw_unused = ^{dmw0[28], dmw0[24:6], dmw0[2:1], dmw1[28], dmw1[24:6], dmw1[2:1]};

    assign s2_adv        = ~s2_v_q | bus.rsp_ready;
    assign s1_free       = ~s1_v_q | s2_adv;
    assign bus.req_ready = s1_free & ~flush;
    assign req_fire      = bus.req_valid & bus.req_ready;

    // Unpack the entry vector and compute per-entry match against the request
    always_comb begin
        for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
            ents[i]  = lookup[i*ENTRY_W +: ENTRY_W];
            match[i] = ents[i].e & (ents[i].g | (ents[i].asid == cur_asid)) &
                       (((ents[i].ps == 6'd12) & (ents[i].vppn == bus.req_vaddr[31:13])) |
                        ((ents[i].ps == 6'd21) & (ents[i].vppn[18:9] == bus.req_vaddr[31:22])));
        end
    end

    // Lowest-index match wins; select the odd/even physical half
    always_comb begin
        tlb_hit = 1'b0;
        hit_idx = '0;
        for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
            if (match[i] && !tlb_hit) begin
                tlb_hit = 1'b1;
                hit_idx = IDX_WID'(i);
            end
        end
        sel     = ents[hit_idx];
        odd     = (sel.ps == 6'd12) ? bus.req_vaddr[12] : bus.req_vaddr[21];
        phy_sel = tlb_hit ? (odd ? sel.phy[1] : sel.phy[0]) : '0;
    end

    // Mode decision at accept: DA > DMW0 > DMW1 > TLB
    always_comb begin
        dmw0_hit = (bus.req_vaddr[31:29] == dmw0[31:29]) &&
                   (((cur_plv == 2'd0) && dmw0[0]) || ((cur_plv == 2'd3) && dmw0[3]));
        dmw1_hit = (bus.req_vaddr[31:29] == dmw1[31:29]) &&
                   (((cur_plv == 2'd0) && dmw1[0]) || ((cur_plv == 2'd3) && dmw1[3]));
        mode_d = MODE_TLB;
        seg_d  = '0;
        dmat_d = '0;
        if (crmd_da) begin
            mode_d = MODE_DA;
            dmat_d = crmd_datm;
        end else if (dmw0_hit) begin
            mode_d = MODE_DMW;
            seg_d  = dmw0[27:25];
            dmat_d = dmw0[5:4];
        end else if (dmw1_hit) begin
            mode_d = MODE_DMW;
            seg_d  = dmw1[27:25];
            dmat_d = dmw1[5:4];
        end
    end

    // S2 result formation from the S1 snapshot
    always_comb begin
        s2_paddr_d = s1_vaddr_q;
        s2_mat_d   = s1_dmat_q;
        s2_exc_d   = 1'b0;
        s2_ecode_d = '0;
        case (s1_mode_q)
            MODE_DA:  ;
            MODE_DMW: s2_paddr_d = {s1_seg_q, s1_vaddr_q[28:0]};
            default: begin
                s2_mat_d   = s1_phy_q.mat;
                s2_paddr_d = s1_ps21_q ? {s1_phy_q.ppn[19:9], s1_vaddr_q[20:0]}
                                       : {s1_phy_q.ppn, s1_vaddr_q[11:0]};
                if (!s1_hit_q) begin
                    s2_paddr_d = '0;
                    s2_exc_d   = 1'b1;
                    s2_ecode_d = 6'h3F;
                end else if (!s1_phy_q.v) begin
                    s2_exc_d   = 1'b1;
                    s2_ecode_d = (s1_type_q == 2'd0) ? 6'h03 :
                                 (s1_type_q == 2'd2) ? 6'h02 : 6'h01;
                end else if (s1_plv_q > s1_phy_q.plv) begin
                    s2_exc_d   = 1'b1;
                    s2_ecode_d = 6'h07;
                end else if ((s1_type_q == 2'd2) && !s1_phy_q.d) begin
                    s2_exc_d   = 1'b1;
                    s2_ecode_d = 6'h04;
                end
            end
        endcase
    end

    // Pipeline registers: S1 capture on accept, S2 load on advance, flush kills both
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_v_q     <= 1'b0;
            s1_vaddr_q <= '0;
            s1_type_q  <= '0;
            s1_plv_q   <= '0;
            s1_mode_q  <= MODE_DA;
            s1_seg_q   <= '0;
            s1_dmat_q  <= '0;
            s1_hit_q   <= 1'b0;
            s1_ps21_q  <= 1'b0;
            s1_phy_q   <= '0;
            s2_v_q     <= 1'b0;
            s2_paddr_q <= '0;
            s2_mat_q   <= '0;
            s2_exc_q   <= 1'b0;
            s2_ecode_q <= '0;
            s2_vaddr_q <= '0;
        end else if (flush) begin
            s1_v_q <= 1'b0;
            s2_v_q <= 1'b0;
        end else begin
            if (s2_adv) begin
                s2_v_q <= s1_v_q;
                if (s1_v_q) begin
                    s2_paddr_q <= s2_paddr_d;
                    s2_mat_q   <= s2_mat_d;
                    s2_exc_q   <= s2_exc_d;
                    s2_ecode_q <= s2_ecode_d;
                    s2_vaddr_q <= s1_vaddr_q;
                end
            end
            if (s1_free) begin
                s1_v_q <= req_fire;
                if (req_fire) begin
                    s1_vaddr_q <= bus.req_vaddr;
                    s1_type_q  <= bus.req_type;
                    s1_plv_q   <= cur_plv;
                    s1_mode_q  <= mode_d;
                    s1_seg_q   <= seg_d;
                    s1_dmat_q  <= dmat_d;
                    s1_hit_q   <= tlb_hit;
                    s1_ps21_q  <= (sel.ps == 6'd21);
                    s1_phy_q   <= phy_sel;
                end
            end
        end
    end

    assign bus.rsp_valid = s2_v_q;
    assign bus.rsp_paddr = s2_paddr_q;
    assign bus.rsp_mat   = s2_mat_q;
    assign bus.rsp_exc   = s2_exc_q;
    assign bus.rsp_ecode = s2_ecode_q;
    assign bus.rsp_vaddr = s2_vaddr_q;

endmodule

// File: tb/tb_mmu_xlate.sv
// Directed self-checking bench for mmu_xlate.
module tb_mmu_xlate;

    localparam int unsigned EN = 16;

    typedef struct packed {
        logic [19:0] ppn;
        logic [1:0]  plv;
        logic [1:0]  mat;
        logic        d;
        logic        v;
    } tlb_phy_t;

    typedef struct packed {
        logic          e;
        logic          g;
        logic [18:0]   vppn;
        logic [5:0]    ps;
        logic [9:0]    asid;
        tlb_phy_t [1:0] phy;
    } tlb_entry_t;

    localparam int EW = $bits(tlb_entry_t);

    logic        clk = 1'b0;
    logic        rstn;
    logic        flush;
    logic [1:0]  cur_plv;
    logic [9:0]  cur_asid;
    logic        crmd_da;
    logic [1:0]  crmd_datm;
    logic [31:0] dmw0, dmw1;
    tlb_entry_t  ents [EN];
    logic [EN*EW-1:0] lookup;

    int checks = 0;
    int errors = 0;

    mmu_xlate_if bus ();

    mmu_xlate #(.ENTRY_NUM(16), .IDX_WID(4)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (flush),
        .cur_plv   (cur_plv),
        .cur_asid  (cur_asid),
        .crmd_da   (crmd_da),
        .crmd_datm (crmd_datm),
        .dmw0      (dmw0),
        .dmw1      (dmw1),
        .lookup    (lookup),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    always_comb begin
        lookup = '0;
        for (int i = 0; i < EN; i++) lookup[i*EW +: EW] = ents[i];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_rsp(input string tag, input logic [31:0] pa, input logic [1:0] mat,
                           input logic exc, input logic [5:0] ec, input logic [31:0] va);
        chk({tag, ".valid"}, bus.rsp_valid, 1);
        chk({tag, ".paddr"}, bus.rsp_paddr, pa);
        chk({tag, ".mat"},   bus.rsp_mat, mat);
        chk({tag, ".exc"},   bus.rsp_exc, exc);
        chk({tag, ".ecode"}, bus.rsp_ecode, ec);
        chk({tag, ".vaddr"}, bus.rsp_vaddr, va);
    endtask

    // Single request into an idle pipeline; response expected exactly 2 cycles after accept
    task automatic xlate(input string tag, input logic [31:0] va, input logic [1:0] typ,
                         input logic [31:0] pa, input logic [1:0] mat,
                         input logic exc, input logic [5:0] ec);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_vaddr = va;
        bus.req_type  = typ;
        #1;
        chk({tag, ".ready"}, bus.req_ready, 1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk({tag, ".lat1"}, bus.rsp_valid, 0);
        @(negedge clk);
        chk_rsp(tag, pa, mat, exc, ec, va);
    endtask

    initial begin
        rstn = 1'b0;
        flush = 1'b0;
        cur_plv = 2'd0;
        cur_asid = 10'd0;
        crmd_da = 1'b0;
        crmd_datm = 2'd0;
        dmw0 = '0;
        dmw1 = '0;
        bus.req_valid = 1'b0;
        bus.req_vaddr = '0;
        bus.req_type = 2'd0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < EN; i++) ents[i] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst.valid", bus.rsp_valid, 0);
        chk("rst.paddr", bus.rsp_paddr, 0);
        chk("rst.mat",   bus.rsp_mat, 0);
        chk("rst.exc",   bus.rsp_exc, 0);
        chk("rst.ecode", bus.rsp_ecode, 0);
        chk("rst.vaddr", bus.rsp_vaddr, 0);
        rstn = 1'b1;
        @(negedge clk);

        // Direct-address mode, and its priority over a matching DMW
        crmd_da = 1'b1; crmd_datm = 2'd1;
        xlate("da", 32'h1C00_0000, 2'd1, 32'h1C00_0000, 2'd1, 1'b0, 6'h00);
        crmd_datm = 2'd2; dmw0 = 32'h8000_0011;
        xlate("da_prio", 32'h9000_1234, 2'd1, 32'h9000_1234, 2'd2, 1'b0, 6'h00);

        // DMW0 at PLV0, then PLV3 falls through to TLB with no match
        crmd_da = 1'b0;
        xlate("dmw0", 32'h9000_1234, 2'd1, 32'h1000_1234, 2'd1, 1'b0, 6'h00);
        cur_plv = 2'd3;
        xlate("dmw0_plv3", 32'h9000_1234, 2'd1, 32'h0000_0000, 2'd0, 1'b1, 6'h3F);

        // DMW1 at PLV3; PLV1 never hits; DMW0 wins over DMW1 on the same segment
        dmw1 = 32'hA200_0028;
        xlate("dmw1", 32'hB000_0040, 2'd2, 32'h3000_0040, 2'd2, 1'b0, 6'h00);
        cur_plv = 2'd1;
        xlate("dmw1_plv1", 32'hB000_0040, 2'd1, 32'h0000_0000, 2'd0, 1'b1, 6'h3F);
        cur_plv = 2'd3; dmw0 = 32'hA400_0018;
        xlate("dmw_prio", 32'hB000_0040, 2'd1, 32'h5000_0040, 2'd1, 1'b0, 6'h00);
        dmw0 = '0; dmw1 = '0;

        // TLB entry 5, 4 KiB page, odd half
        ents[5].e = 1'b1; ents[5].g = 1'b0; ents[5].asid = 10'd7;
        ents[5].vppn = 19'h00010; ents[5].ps = 6'd12;
        ents[5].phy[1] = '{ppn: 20'hABCDE, plv: 2'd3, mat: 2'd1, d: 1'b0, v: 1'b1};
        cur_asid = 10'd7; cur_plv = 2'd3;
        xlate("tlb_pme", 32'h0002_1008, 2'd2, 32'hABCD_E008, 2'd1, 1'b1, 6'h04);
        xlate("tlb_ld",  32'h0002_1008, 2'd1, 32'hABCD_E008, 2'd1, 1'b0, 6'h00);
        cur_asid = 10'd8;
        xlate("tlb_asid", 32'h0002_1008, 2'd1, 32'h0000_0000, 2'd0, 1'b1, 6'h3F);
        ents[5].g = 1'b1;
        xlate("tlb_g", 32'h0002_1008, 2'd1, 32'hABCD_E008, 2'd1, 1'b0, 6'h00);
        ents[5].phy[1].v = 1'b0;
        xlate("tlb_pif", 32'h0002_1008, 2'd0, 32'hABCD_E008, 2'd1, 1'b1, 6'h03);
        xlate("tlb_pil", 32'h0002_1008, 2'd1, 32'hABCD_E008, 2'd1, 1'b1, 6'h01);
        xlate("tlb_pis", 32'h0002_1008, 2'd2, 32'hABCD_E008, 2'd1, 1'b1, 6'h02);
        ents[5].phy[1].v = 1'b1; ents[5].phy[1].plv = 2'd0;
        xlate("tlb_ppi",    32'h0002_1008, 2'd1, 32'hABCD_E008, 2'd1, 1'b1, 6'h07);
        xlate("tlb_ppi_st", 32'h0002_1008, 2'd2, 32'hABCD_E008, 2'd1, 1'b1, 6'h07);
        cur_plv = 2'd0;
        xlate("tlb_pme0", 32'h0002_1008, 2'd2, 32'hABCD_E008, 2'd1, 1'b1, 6'h04);
        xlate("tlb_even", 32'h0002_0008, 2'd1, 32'h0000_0008, 2'd0, 1'b1, 6'h01);

        // 2 MiB pages: entries 2 and 9 both match, lowest index wins; even half too
        ents[2].e = 1'b1; ents[2].g = 1'b1; ents[2].ps = 6'd21;
        ents[2].vppn = {10'h155, 9'h000};
        ents[2].phy[1] = '{ppn: 20'h12345, plv: 2'd3, mat: 2'd2, d: 1'b1, v: 1'b1};
        ents[2].phy[0] = '{ppn: 20'h00200, plv: 2'd3, mat: 2'd3, d: 1'b1, v: 1'b1};
        ents[9] = ents[2];
        ents[9].phy[1].ppn = 20'hFFFFF;
        xlate("tlb21_odd",  32'h5560_ABCD, 2'd1, 32'h1220_ABCD, 2'd2, 1'b0, 6'h00);
        xlate("tlb21_even", 32'h5540_ABCD, 2'd2, 32'h0020_ABCD, 2'd3, 1'b0, 6'h00);

        // Unsupported page size never matches
        ents[3].e = 1'b1; ents[3].g = 1'b1; ents[3].ps = 6'd14; ents[3].vppn = 19'h38000;
        ents[3].phy[0] = '{ppn: 20'h11111, plv: 2'd3, mat: 2'd1, d: 1'b1, v: 1'b1};
        xlate("tlb_ps14", 32'h7000_0000, 2'd1, 32'h0000_0000, 2'd0, 1'b1, 6'h3F);

        // Snapshot: entry rewrite after accept does not affect the in-flight request
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_vaddr = 32'h0002_1008; bus.req_type = 2'd1;
        #1 chk("snap.ready", bus.req_ready, 1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        ents[5].e = 1'b0; ents[5].phy[1].ppn = 20'h11111;
        @(negedge clk);
        chk_rsp("snap", 32'hABCD_E008, 2'd1, 1'b0, 6'h00, 32'h0002_1008);

        // Back-to-back with 3 stalled cycles after the first response
        crmd_da = 1'b1; crmd_datm = 2'd0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_vaddr = 32'h1000_0000; bus.req_type = 2'd1;
        #1 chk("bp.r0", bus.req_ready, 1);
        @(negedge clk);
        bus.req_vaddr = 32'h1000_0004;
        #1 chk("bp.r1", bus.req_ready, 1);
        @(negedge clk);
        chk_rsp("bp.a0", 32'h1000_0000, 2'd0, 1'b0, 6'h00, 32'h1000_0000);
        bus.req_vaddr = 32'h1000_0008;
        bus.rsp_ready = 1'b0;
        #1 chk("bp.full", bus.req_ready, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_rsp("bp.hold", 32'h1000_0000, 2'd0, 1'b0, 6'h00, 32'h1000_0000);
            chk("bp.hold_ready", bus.req_ready, 0);
        end
        bus.rsp_ready = 1'b1;
        #1 chk("bp.r2", bus.req_ready, 1);
        @(negedge clk);
        chk_rsp("bp.a1", 32'h1000_0004, 2'd0, 1'b0, 6'h00, 32'h1000_0004);
        bus.req_vaddr = 32'h1000_000C;
        #1 chk("bp.r3", bus.req_ready, 1);
        @(negedge clk);
        chk_rsp("bp.a2", 32'h1000_0008, 2'd0, 1'b0, 6'h00, 32'h1000_0008);
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk_rsp("bp.a3", 32'h1000_000C, 2'd0, 1'b0, 6'h00, 32'h1000_000C);
        @(negedge clk);
        chk("bp.drain", bus.rsp_valid, 0);

        // Flush with both stages full and a new request offered
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_vaddr = 32'h2000_0000;
        @(negedge clk);
        bus.req_vaddr = 32'h2000_0004;
        @(negedge clk);
        chk("fl.pre_valid", bus.rsp_valid, 1);
        flush = 1'b1;
        bus.req_vaddr = 32'h2000_0008;
        #1 chk("fl.ready", bus.req_ready, 0);
        @(negedge clk);
        flush = 1'b0;
        chk("fl.valid0", bus.rsp_valid, 0);
        bus.req_vaddr = 32'h2000_000C;
        #1 chk("fl.ready_after", bus.req_ready, 1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("fl.valid1", bus.rsp_valid, 0);
        @(negedge clk);
        chk_rsp("fl.new", 32'h2000_000C, 2'd0, 1'b0, 6'h00, 32'h2000_000C);
        @(negedge clk);
        chk("fl.drain", bus.rsp_valid, 0);

        // Asynchronous reset mid-operation
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_vaddr = 32'h3000_0000;
        @(negedge clk);
        bus.req_vaddr = 32'h3000_0004;
        @(negedge clk);
        chk("ar.pre_valid", bus.rsp_valid, 1);
        bus.req_valid = 1'b0;
        rstn = 1'b0;
        #1;
        chk("ar.valid", bus.rsp_valid, 0);
        chk("ar.paddr", bus.rsp_paddr, 0);
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ar.no_rsp", bus.rsp_valid, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
